// File: rtl/ram8_arbiter.sv
// Round-robin arbiter between two requesters and a single-port RAM macro.
// Clears the RAM after reset, then issues one command per cycle and routes read data back.
module ram8_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                init_done
);

  // state  | meaning
  // S_INIT | clearing the RAM, one address per cycle, requesters held off
  // S_RUN  | arbitrating and issuing requester commands
  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_left;
  logic              last_grant;
  logic              grant;
  logic              xfer;
  logic              pipe0_vld, pipe1_vld;
  logic              pipe0_id, pipe1_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_INIT && init_left == '0) state_nxt = S_RUN;
  end

  always_comb begin
    grant     = 1'b0;
    req_ready = 2'b00;
    if (state == S_RUN) begin
      case (req_valid)
        2'b01:   begin grant = 1'b0;        req_ready = 2'b01; end
        2'b10:   begin grant = 1'b1;        req_ready = 2'b10; end
        2'b11:   begin grant = ~last_grant; req_ready = last_grant ? 2'b01 : 2'b10; end
        default: begin grant = 1'b0;        req_ready = 2'b00; end
      endcase
    end
  end

  assign xfer      = |(req_valid & req_ready);
  assign init_done = (state == S_RUN);

  // Down-counter from depth-1 to 0; its complement walks the addresses upward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   init_left <= '1;
    else if (state == S_INIT && init_left != '0) init_left <= init_left - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (state == S_INIT) begin
      ram_en    <= 1'b1;
      ram_we    <= 1'b1;
      ram_addr  <= ~init_left;
      ram_wdata <= '0;
    end else if (xfer) begin
      ram_en    <= 1'b1;
      ram_we    <= grant ? req_we[1] : req_we[0];
      ram_addr  <= grant ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
      ram_wdata <= grant ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    end else begin
      ram_en    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_grant <= 1'b1;
    else if (xfer) last_grant <= grant;
  end

  // Read tracking: stage 0 aligns with the macro command, stage 1 with its data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe0_vld <= 1'b0;
      pipe0_id  <= 1'b0;
      pipe1_vld <= 1'b0;
      pipe1_id  <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
    end else begin
      pipe0_vld <= xfer & ~(grant ? req_we[1] : req_we[0]);
      pipe0_id  <= grant;
      pipe1_vld <= pipe0_vld;
      pipe1_id  <= pipe0_id;
      rsp_valid <= {pipe1_vld & pipe1_id, pipe1_vld & ~pipe1_id};
      if (pipe1_vld) rsp_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram8_arbiter.sv
// Bench for ram8_arbiter: a RAM macro model, a transaction-level reference model
// compared every cycle, and directed scenarios with hand-computed expectations.
module tb_ram8_arbiter;
  localparam int AW = 3;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            ram_en, ram_we, init_done;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram8_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .init_done(init_done)
  );

  // Macro: synchronous single port, not reset, starts with non-zero garbage.
  logic [DW-1:0] mem [8] = '{8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'h5E, 8'h5F, 8'h60, 8'h61};
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents in acceptance order and a queue of due responses.
  typedef struct { int due; int id; logic [DW-1:0] data; } rsp_t;
  rsp_t          rq[$];
  logic [DW-1:0] ref_mem [8];
  int            mlg = 1;
  bit            pend = 0;
  logic          pend_we, hold_we;
  logic [AW-1:0] pend_addr, hold_addr;
  logic [DW-1:0] pend_wdata, hold_wdata;
  int            grant_log[$];
  bit            log_on = 0;
  int            rsp_cnt[2] = '{0, 0};

  always @(negedge clk) begin
    logic [1:0] exp_ready;
    int g;
    if (rst) begin
      rq.delete();
      mlg  = 1;
      pend = 0;
      for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    end else begin
      if (cyc == 0) begin
        check("ram_en_idle_pre", 32'(ram_en), 32'd0);
      end else if (cyc <= 8) begin
        check("init_en",    32'(ram_en),    32'd1);
        check("init_we",    32'(ram_we),    32'd1);
        check("init_addr",  32'(ram_addr),  32'(cyc - 1));
        check("init_wdata", 32'(ram_wdata), 32'd0);
        hold_we = 1'b1; hold_addr = AW'(cyc - 1); hold_wdata = '0;
      end else if (pend) begin
        check("issue_en",    32'(ram_en),    32'd1);
        check("issue_we",    32'(ram_we),    32'(pend_we));
        check("issue_addr",  32'(ram_addr),  32'(pend_addr));
        check("issue_wdata", 32'(ram_wdata), 32'(pend_wdata));
        hold_we = pend_we; hold_addr = pend_addr; hold_wdata = pend_wdata;
        pend = 0;
      end else begin
        check("idle_en",    32'(ram_en),    32'd0);
        check("hold_we",    32'(ram_we),    32'(hold_we));
        check("hold_addr",  32'(ram_addr),  32'(hold_addr));
        check("hold_wdata", 32'(ram_wdata), 32'(hold_wdata));
      end
      check("init_done", 32'(init_done), 32'(cyc >= 8));

      if (rsp_valid[0]) rsp_cnt[0]++;
      if (rsp_valid[1]) rsp_cnt[1]++;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        check("rsp_valid", 32'(rsp_valid), 32'(rq[0].id == 1 ? 2 : 1));
        check("rsp_rdata", 32'(rsp_rdata), 32'(rq[0].data));
        void'(rq.pop_front());
      end else begin
        check("rsp_quiet", 32'(rsp_valid), 32'd0);
      end

      exp_ready = 2'b00;
      if (cyc >= 8) begin
        if (req_valid == 2'b11) exp_ready = (mlg == 1) ? 2'b01 : 2'b10;
        else                    exp_ready = req_valid;
      end
      check("req_ready", 32'(req_ready), 32'(exp_ready));

      if (exp_ready != 2'b00) begin
        g          = exp_ready[1] ? 1 : 0;
        mlg        = g;
        pend       = 1;
        pend_we    = req_we[g];
        pend_addr  = (g == 1) ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
        pend_wdata = (g == 1) ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
        if (pend_we) ref_mem[pend_addr] = pend_wdata;
        else         rq.push_back('{cyc + 3, g, ref_mem[pend_addr]});
        if (log_on) grant_log.push_back(g);
      end
    end
  end

  task automatic drive(input int id, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[id] = we;
    if (id == 0) begin req_addr[AW-1:0] = a;    req_wdata[DW-1:0] = d;    end
    else         begin req_addr[2*AW-1:AW] = a; req_wdata[2*DW-1:DW] = d; end
    req_valid[id] = 1'b1;
  endtask

  task automatic send(input int id, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output int acc);
    bit got = 0;
    acc = -1;
    drive(id, we, a, d);
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin got = 1; acc = cyc; end
    end
    check("accept_in_time", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input logic [1:0] vec, input logic [DW-1:0] d, input int acc);
    bit got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        got = 1;
        check("lit_rsp_vec",     32'(rsp_valid), 32'(vec));
        check("lit_rsp_data",    32'(rsp_rdata), 32'(d));
        check("lit_rsp_latency", 32'(cyc - acc), 32'd3);
      end
    end
    check("rsp_in_time", 32'(got), 32'd1);
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_ram_en",    32'(ram_en),    32'd0);
    check("rst_ram_we",    32'(ram_we),    32'd0);
    check("rst_ram_addr",  32'(ram_addr),  32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int acc;
    int c0, c1;
    int exp_g[6] = '{0, 1, 0, 1, 0, 1};

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b0;

    // Read every address from requester 0 once the clear completes.
    c0 = rsp_cnt[0];
    for (int a = 0; a < 8; a++) send(0, 1'b0, AW'(a), 8'h00, acc);
    repeat (5) @(posedge clk);
    #1;
    check("lit_readall_count", 32'(rsp_cnt[0] - c0), 32'd8);

    // Requester 1 write then read of the same address.
    send(1, 1'b1, 3'd3, 8'hA5, acc);
    send(1, 1'b0, 3'd3, 8'h00, acc);
    wait_rsp(2'b10, 8'hA5, acc);
    repeat (3) @(posedge clk);
    #1;

    // Seed addresses 1 and 2, then both requesters read continuously.
    send(0, 1'b1, 3'd1, 8'h11, acc);
    send(1, 1'b1, 3'd2, 8'h22, acc);
    c0 = rsp_cnt[0]; c1 = rsp_cnt[1];
    log_on = 1;
    drive(0, 1'b0, 3'd1, 8'h00);
    drive(1, 1'b0, 3'd2, 8'h00);
    repeat (6) @(posedge clk);
    #1;
    req_valid = 2'b00;
    log_on = 0;
    check("lit_grant_count", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < grant_log.size() && i < 6; i++)
      check("lit_grant_seq", 32'(grant_log[i]), 32'(exp_g[i]));
    repeat (5) @(posedge clk);
    #1;
    check("lit_alt_rsp0", 32'(rsp_cnt[0] - c0), 32'd3);
    check("lit_alt_rsp1", 32'(rsp_cnt[1] - c1), 32'd3);

    // Requester 0 streaming, requester 1 pulses once.
    drive(0, 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    check("lit_pulse_r0_first", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    drive(1, 1'b1, 3'd5, 8'h55);
    @(negedge clk);
    check("lit_pulse_r1_won", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("lit_pulse_r0_resume", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Reset with two reads in flight.
    c0 = rsp_cnt[0]; c1 = rsp_cnt[1];
    drive(0, 1'b0, 3'd3, 8'h00);
    drive(1, 1'b0, 3'd2, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst = 1'b1;
    #1;
    check_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("lit_dropped_rsp", 32'((rsp_cnt[0] - c0) + (rsp_cnt[1] - c1)), 32'd0);
    send(0, 1'b0, 3'd3, 8'h00, acc);
    check("lit_reinit_accept_cyc", 32'(acc), 32'd8);
    wait_rsp(2'b01, 8'h00, acc);

    repeat (4) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
